// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the instruction-fetch queue.
package fetch_queue_pkg;

    localparam int unsigned FQ_STATE_W = 2;

    typedef enum logic [FQ_STATE_W-1:0] {
        FQ_IDLE    = 2'd0,
        FQ_REQ     = 2'd1,
        FQ_DISCARD = 2'd2
    } fq_state_e;

    // A read is on the memory port in every state except IDLE.
    function automatic logic fq_reads(input fq_state_e s);
        return (s == FQ_REQ) || (s == FQ_DISCARD);
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer with push, pop, synchronous flush and registered occupancy.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_d;

    always_comb begin
        count_d = count;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count + CW'(push) - CW'(pop);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_d;
            valid <= (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding
// reads and buffers returned words with their PC for the decode side.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned          WORD_SIZE = 16,
    parameter int unsigned          DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    output logic                         i_readM,
    output logic [WORD_SIZE-1:0]         i_address,
    input  logic [WORD_SIZE-1:0]         i_data,
    input  logic                         input_ready,
    input  logic                         redirect,
    input  logic [WORD_SIZE-1:0]         redirect_pc,
    output logic                         inst_valid,
    output logic [WORD_SIZE-1:0]         inst,
    output logic [WORD_SIZE-1:0]         inst_pc,
    input  logic                         inst_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WORD_SIZE-1:0]         num_fetched
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned EW = 2 * WORD_SIZE;

    fq_state_e            state;
    fq_state_e            state_d;
    logic [WORD_SIZE-1:0] fetch_pc;
    logic [WORD_SIZE-1:0] fetch_pc_d;
    logic [WORD_SIZE-1:0] addr_d;
    logic                 push;
    logic                 pop;
    logic [CW-1:0]        post_count;
    logic [EW-1:0]        head;

    assign pop        = inst_valid && inst_ready;
    assign post_count = count + CW'(1) - CW'(pop);

    // Next-state, fetch PC and pending address; redirect outranks push.
    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        push       = 1'b0;
        unique case (state)
            FQ_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = FQ_REQ;
                end else if (count < CW'(DEPTH)) begin
                    state_d = FQ_REQ;
                end
            end
            FQ_REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = input_ready ? FQ_REQ : FQ_DISCARD;
                end else if (input_ready) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc + WORD_SIZE'(1);
                    state_d    = (post_count < CW'(DEPTH)) ? FQ_REQ : FQ_IDLE;
                end
            end
            FQ_DISCARD: begin
                if (redirect) fetch_pc_d = redirect_pc;
                if (input_ready) state_d = FQ_REQ;
            end
            default: state_d = FQ_IDLE;
        endcase
        // A new read always targets the (possibly just updated) fetch PC;
        // otherwise the in-flight address is held until it completes.
        addr_d = (state_d == FQ_REQ) ? fetch_pc_d : i_address;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FQ_IDLE;
            fetch_pc    <= RESET_PC;
            i_address   <= RESET_PC;
            i_readM     <= 1'b0;
            num_fetched <= '0;
        end else begin
            state     <= state_d;
            fetch_pc  <= fetch_pc_d;
            i_address <= addr_d;
            i_readM   <= fq_reads(state_d);
            if (pop) num_fetched <= num_fetched + WORD_SIZE'(1);
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect),
        .wdata   ({fetch_pc, i_data}),
        .rdata   (head),
        .count   (count),
        .valid   (inst_valid)
    );

    assign inst_pc = head[EW-1 -: WORD_SIZE];
    assign inst    = head[WORD_SIZE-1:0];

endmodule
